// File: rtl/bit_unstuffer_if.sv
// Bit-stream bus between the NRZI decoder side and the receive shift register side.
// The master drives the packet framing and the raw bits; the slave returns the unstuffed stream.
interface bit_unstuffer_if #(
    parameter int CNT_W = 11
);
    logic             rx_start;
    logic             rx_eop;
    logic             in_valid;
    logic             in_bit;
    logic             out_valid;
    logic             out_bit;
    logic             stuff_err;
    logic             active;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output rx_start, rx_eop, in_valid, in_bit,
        input  out_valid, out_bit, stuff_err, active, bit_cnt
    );

    modport slave (
        input  rx_start, rx_eop, in_valid, in_bit,
        output out_valid, out_bit, stuff_err, active, bit_cnt
    );
endinterface

// File: rtl/bit_unstuffer.sv
// Receive-side USB bit unstuffer: passes the PID through, then removes the 0 stuffed
// after every RUN_LEN consecutive 1s and flags a 1 found in a stuff position.
module bit_unstuffer #(
    parameter int PID_BITS = 8,
    parameter int RUN_LEN  = 6,
    parameter int CNT_W    = 11
) (
    input  logic           clock,
    input  logic           reset,
    bit_unstuffer_if.slave bus
);
    localparam int PC_W = $clog2(PID_BITS + 1);
    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [PC_W-1:0] PID_LAST = PC_W'(PID_BITS);
    localparam logic [RC_W-1:0] RUN_LAST = RC_W'(RUN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_DROP,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pid_q, pid_d;
    logic [RC_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             bit_q, bit_d;
    logic             err_q, err_d;
    logic             active_q, active_d;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        bit_d   = 1'b0;
        err_d   = 1'b0;

        // A restart takes effect before the coincident bit, which becomes PID bit 0.
        if (bus.rx_start) begin
            state_d = S_PID;
            pid_d   = '0;
            run_d   = '0;
            cnt_d   = '0;
        end

        if (bus.in_valid) begin
            unique case (state_d)
                S_PID: begin
                    valid_d = 1'b1;
                    bit_d   = bus.in_bit;
                    cnt_d   = cnt_d + CNT_W'(1);
                    pid_d   = pid_d + PC_W'(1);
                    if (pid_d == PID_LAST) begin
                        state_d = S_DATA;
                        run_d   = '0;
                    end
                end
                S_DATA: begin
                    valid_d = 1'b1;
                    bit_d   = bus.in_bit;
                    cnt_d   = cnt_d + CNT_W'(1);
                    if (bus.in_bit) begin
                        run_d = run_d + RC_W'(1);
                        if (run_d == RUN_LAST) state_d = S_DROP;
                    end else begin
                        run_d = '0;
                    end
                end
                S_DROP: begin
                    if (bus.in_bit) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        run_d   = '0;
                        state_d = S_DATA;
                    end
                end
                default: ;
            endcase
        end

        // End of packet applies after the coincident bit is handled; rx_start wins.
        if (bus.rx_eop && !bus.rx_start && state_d != S_IDLE) begin
            state_d = S_IDLE;
        end

        active_d = (state_d == S_PID) || (state_d == S_DATA) || (state_d == S_DROP);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pid_q    <= '0;
            run_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            bit_q    <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pid_q    <= pid_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_bit   = bit_q;
    assign bus.stuff_err = err_q;
    assign bus.active    = active_q;
    assign bus.bit_cnt   = cnt_q;
endmodule

// File: doc/bit_unstuffer.md
# bit_unstuffer

Receive-side USB bit unstuffer, the counterpart of the transmit bit stuffer. It sits between the NRZI decoder and the receive shift register/CRC checker. It passes the 8 PID bits through untouched, then removes the stuffed 0 that follows every run of six consecutive 1s. A 1 found where a stuffed 0 is required is a stuff error; the block flags it and discards the rest of the packet.

## Interface
- PID_BITS, default 8: leading bits of each packet exempt from unstuffing.
- RUN_LEN, default 6: consecutive 1s after which a stuffed 0 is expected.
- CNT_W, default 11: width of the delivered-bit counter.

- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_start  in  1  one-cycle pulse: a new packet begins; the next valid bit, or a valid bit in this same cycle, is PID bit 0.
- rx_eop  in  1  one-cycle pulse: end of packet.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  NRZI-decoded, still-stuffed bit.
- out_valid  out  1  out_bit carries a delivered bit this cycle.
- out_bit  out  1  unstuffed bit.
- stuff_err  out  1  one-cycle pulse on a stuff violation.
- active  out  1  high from rx_start until rx_eop, error, or reset.
- bit_cnt  out  CNT_W  bits delivered in the current packet, including PID bits.

## Operation
- State machine:
  - IDLE: in_valid is ignored. rx_start moves to PID and clears pid_cnt, run_cnt and bit_cnt.
  - PID: each valid bit is delivered and pid_cnt increments. When pid_cnt reaches PID_BITS, move to DATA with run_cnt = 0. PID bits never advance run_cnt.
  - DATA: each valid bit is delivered.
    - A 1 increments run_cnt. When run_cnt reaches RUN_LEN, move to DROP.
    - A 0 clears run_cnt.
  - DROP: the next valid bit is not delivered.
    - If it is 0, clear run_cnt and return to DATA.
    - If it is 1, pulse stuff_err and move to ERROR.
  - ERROR: all input is discarded and out_valid stays 0. Leave only on rx_eop (to IDLE), rx_start (to PID) or reset.
- rx_eop in any non-IDLE state moves to IDLE. rx_eop while in DROP is not an error.
- rx_start in any state restarts the packet: all counters clear and the state becomes PID. rx_start has priority over rx_eop in the same cycle.
- When rx_start and in_valid coincide, that bit is PID bit 0.
- When rx_eop and in_valid coincide, the bit is processed normally (delivered or checked) before the move to IDLE.
- Cycles with in_valid = 0 are bubbles. They change no counter and no state, so a run of 1s continues across bubbles.
- bit_cnt increments once per delivered bit and wraps modulo 2^CNT_W. It is held after rx_eop until the next rx_start.
- run_cnt needs only enough width for RUN_LEN and never exceeds RUN_LEN.
- active is 1 in PID, DATA and DROP, and 0 in IDLE and ERROR.

## Timing
- Reset values: state IDLE; out_valid, out_bit, stuff_err, active all 0; bit_cnt 0.
- All outputs are registered. A valid input bit at cycle t appears as out_valid/out_bit at cycle t+1.
- A removed stuff bit produces no output cycle: out_valid is 0 at t+1.
- stuff_err is high at t+1 for a violating bit at t, for exactly one cycle.
- bit_cnt reflects deliveries up to and including out_valid at cycle t+1.
- active rises the cycle after rx_start. It falls the cycle after rx_eop or after the violating bit.
- No backpressure: the downstream block must accept every out_valid cycle.
- Reset in mid-packet takes effect at the next edge. Outputs return to reset values and any partial run is discarded.

## Test plan
- PID 8'b11111111 then data 1,0: all 10 bits delivered, no removal, bit_cnt = 10, stuff_err never asserted.
- PID 8'h2D then data 1,1,1,1,1,1,0,1: the 0 after six 1s is removed. Output is the PID followed by 1,1,1,1,1,1,1, with a one-cycle out_valid gap; bit_cnt = 15.
- PID then data 1,1,1,1,1,1,1:
  - six 1s delivered;
  - stuff_err pulses once, one cycle after the seventh 1;
  - subsequent bits are dropped and active is 0 until rx_eop.
- PID then data 1,1,1,0,1,1 with in_valid bubbles between bits: the 0 resets the run, nothing is removed, and every bit is delivered in order.
- Data 1,1,1,1,1,1 then rx_eop before the stuff bit: no stuff_err, state IDLE, active = 0.
- Reset asserted during DATA with run_cnt = 5: all outputs reset. A new rx_start plus PID plus 1,0 delivers 10 bits with no removal.
